i2c_reg_master: RTL and testbench

Bit-level I2C master that runs one complete 8-bit-register write or read transaction per request. Sits directly below `i2c_config` in the HDMI transmitter bring-up path. `i2c_config` sequences the register table and hands each entry to this block. This block drives the open-drain `hdmi_scl`/`hdmi_sda` pads through the top-level tri-state wrappers. Clock stretching and multi-master arbitration are not supported.

---
 rtl/i2c_reg_master.sv | 166 ++++++++++++++++
 tb/tb_i2c_reg_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_master.sv
// Bit-level I2C master: one 8-bit register write or read transaction per request.
// Open-drain pads are driven through scl_oe/sda_oe (1 = pull low).
module i2c_reg_master #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_read,
    input  logic [6:0] req_dev_addr,
    input  logic [7:0] req_reg_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic       rsp_nack,
    output logic [7:0] rsp_rdata,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);
    localparam int unsigned     CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [1:0]    q, q_n;
    logic [1:0]    phase, phase_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          nack_f, nack_n;
    logic          read_r;
    logic [6:0]    dev_r;
    logic [7:0]    reg_r, wdata_r;
    logic          sda_meta, sda_s;
    logic          scl_n, sda_n;
    logic          tick, accept;

    assign tick      = (cnt == CNT_MAX);
    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == DONE);

    always_comb begin
        state_n = state;
        q_n     = q;
        bit_n   = bit_idx;
        phase_n = phase;
        shift_n = shift;
        nack_n  = nack_f;
        scl_n   = 1'b0;
        sda_n   = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                state_n = START;
                q_n     = '0;
                phase_n = '0;
                nack_n  = 1'b0;
            end
            DONE: state_n = IDLE;
            default: if (tick) begin
                q_n = q + 2'd1;
                if (q == 2'd2) begin
                    if (state == RX_ACK)  nack_n  = nack_f | sda_s;
                    if (state == RX_BYTE) shift_n = {shift[6:0], sda_s};
                end
                if (q == 2'd3) begin
                    case (state)
                        START, RESTART: begin
                            state_n = TX_BYTE;
                            bit_n   = '0;
                        end
                        TX_BYTE: if (bit_idx == 3'd7) state_n = RX_ACK;
                                 else begin
                                     bit_n   = bit_idx + 3'd1;
                                     shift_n = {shift[6:0], 1'b0};
                                 end
                        RX_ACK: begin
                            bit_n = '0;
                            if (nack_f) state_n = STOP;
                            else begin
                                // phase: 0 = dev addr, 1 = reg addr, 2 = wdata or read-address byte
                                case (phase)
                                    2'd0:    begin phase_n = 2'd1; state_n = TX_BYTE; end
                                    2'd1:    begin phase_n = 2'd2; state_n = read_r ? RESTART : TX_BYTE; end
                                    default: state_n = read_r ? RX_BYTE : STOP;
                                endcase
                            end
                        end
                        RX_BYTE: if (bit_idx == 3'd7) state_n = TX_NACK;
                                 else bit_n = bit_idx + 3'd1;
                        TX_NACK: state_n = STOP;
                        STOP:    state_n = DONE;
                        default: ;
                    endcase
                end
            end
        endcase

        if (state_n == TX_BYTE && state != TX_BYTE) begin
            case (phase_n)
                2'd0:    shift_n = {dev_r, 1'b0};
                2'd1:    shift_n = reg_r;
                default: shift_n = read_r ? {dev_r, 1'b1} : wdata_r;
            endcase
        end

        // Line levels are derived from the next state so the pads are registered.
        case (state_n)
            START:   sda_n = q_n[1];
            TX_BYTE: begin scl_n = ~q_n[1]; sda_n = ~shift_n[7]; end
            RX_ACK, RX_BYTE, TX_NACK: scl_n = ~q_n[1];
            RESTART: begin scl_n = ~q_n[1]; sda_n = (q_n == 2'd3); end
            STOP:    begin scl_n = ~q_n[1]; sda_n = (q_n != 2'd3); end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= '0;
            phase     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            nack_f    <= 1'b0;
            read_r    <= 1'b0;
            dev_r     <= '0;
            reg_r     <= '0;
            wdata_r   <= '0;
            sda_meta  <= 1'b1;
            sda_s     <= 1'b1;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            rsp_nack  <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            sda_meta <= sda_in;
            sda_s    <= sda_meta;
            state    <= state_n;
            q        <= q_n;
            phase    <= phase_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            nack_f   <= nack_n;
            scl_oe   <= scl_n;
            sda_oe   <= sda_n;
            if (accept) begin
                read_r  <= req_read;
                dev_r   <= req_dev_addr;
                reg_r   <= req_reg_addr;
                wdata_r <= req_wdata;
            end
            if (accept || state == IDLE || state == DONE || tick) cnt <= '0;
            else cnt <= cnt + CW'(1);
            if (state_n == DONE && state != DONE) begin
                rsp_nack  <= nack_f;
                rsp_rdata <= (read_r && !nack_f) ? shift : '0;
            end
        end
    end
endmodule

// File: tb/tb_i2c_reg_master.sv
// Self-checking bench for i2c_reg_master: bus-level slave model, protocol monitor
// and a transaction-level reference for bytes, latency and response.
module tb_i2c_reg_master;
    localparam int unsigned D   = 4;
    localparam logic [6:0]  SLV = 7'h39;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_read = 1'b0;
    logic [6:0] req_dev_addr = '0;
    logic [7:0] req_reg_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid, rsp_nack;
    logic [7:0] rsp_rdata;
    logic       scl_oe, sda_oe;
    logic       sda_in;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    i2c_reg_master #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
    );

    // Slave model and bus monitor
    logic       pull = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic       scl_b, sda_b;
    int         sbit = 0, frame = 0;
    logic [7:0] sbyte = '0, s_data = '0;
    bit         s_tx = 0, addr_ack = 0;
    logic [7:0] bus_q[$];
    int         n_start = 0, n_stop = 0, proto_err = 0;
    logic       last_ack = 1'b0;
    int         mcyc = 0, t_fall = 0, t_rise = 0;
    bit         fall_v = 0, rise_v = 0;
    bit         slave_present = 1;
    logic [7:0] slv_rd = '0;

    assign sda_in = ~(sda_oe | pull);

    initial forever begin
        @(negedge clk);
        scl_b = ~scl_oe;
        sda_b = ~(sda_oe | pull);
        mcyc++;
        if (scl_b && prev_scl && sda_b != prev_sda) begin
            if (!sda_b) n_start++; else n_stop++;
            sbit = 0; frame = 0; s_tx = 0; pull = 1'b0;
        end else if (scl_b && !prev_scl) begin
            if (fall_v && (mcyc - t_fall) != 2 * D) proto_err++;
            t_rise = mcyc; rise_v = 1;
            if (sbit < 8) begin
                sbyte = {sbyte[6:0], sda_b};
                if (sbit == 7) bus_q.push_back(sbyte);
                sbit++;
            end else begin
                last_ack = sda_b;
                sbit = 0;
                if (s_tx) s_tx = 0;
                else if (frame == 0 && addr_ack && sbyte[0]) begin
                    s_tx = 1; s_data = slv_rd;
                end
                frame++;
            end
        end else if (!scl_b && prev_scl) begin
            if (rise_v && (mcyc - t_rise) != 2 * D) proto_err++;
            t_fall = mcyc; fall_v = 1;
            if (sbit == 8) begin
                if (s_tx) pull = 1'b0;
                else begin
                    if (frame == 0) addr_ack = slave_present && (sbyte[7:1] == SLV);
                    pull = addr_ack;
                end
            end else if (s_tx) pull = ~s_data[7 - sbit];
            else pull = 1'b0;
        end
        if (req_ready) begin fall_v = 0; rise_v = 0; end
        prev_scl = scl_b;
        prev_sda = sda_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_txn(input bit rd, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, input logic [7:0] rv, input bit poke);
        int         cyc, bq0, s0, p0, e0, exp_lat, exp_starts;
        bit         exp_nack;
        logic [7:0] exp_b[$];
        logic [7:0] exp_rd;
        exp_nack   = !(slave_present && dev == SLV);
        exp_lat    = exp_nack ? 44 * D + 1 : (rd ? 156 * D + 1 : 116 * D + 1);
        exp_starts = (rd && !exp_nack) ? 2 : 1;
        exp_rd     = (rd && !exp_nack) ? rv : 8'h00;
        exp_b.push_back({dev, 1'b0});
        if (!exp_nack) begin
            exp_b.push_back(ra);
            if (rd) begin
                exp_b.push_back({dev, 1'b1});
                exp_b.push_back(rv);
            end else exp_b.push_back(wd);
        end
        slv_rd = rv;
        @(negedge clk);
        bq0 = bus_q.size(); s0 = n_start; p0 = n_stop; e0 = proto_err;
        req_valid = 1'b1; req_read = rd; req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd;
        chk("ready_idle", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_dev_addr = 7'($urandom); req_reg_addr = 8'($urandom); req_wdata = 8'($urandom);
        cyc = 1;
        chk("ready_busy", 32'(req_ready), 0);
        while (!rsp_valid && cyc < exp_lat + 50) begin
            @(posedge clk); #1; cyc++;
            if (poke && cyc == 40) begin
                req_valid = 1'b1; req_read = ~rd; req_dev_addr = ~dev;
                req_reg_addr = ~ra; req_wdata = ~wd;
                chk("poke_ready", 32'(req_ready), 0);
                @(posedge clk); #1; cyc++;
                req_valid = 1'b0;
            end
        end
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("latency", cyc, exp_lat);
        chk("rsp_nack", 32'(rsp_nack), 32'(exp_nack));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        @(posedge clk); #1;
        chk("rsp_pulse", 32'(rsp_valid), 0);
        chk("ready_back", 32'(req_ready), 1);
        chk("rsp_hold", 32'(rsp_rdata), 32'(exp_rd));
        chk("nbytes", bus_q.size() - bq0, exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            if (bq0 + i < bus_q.size()) chk("bus_byte", 32'(bus_q[bq0 + i]), 32'(exp_b[i]));
        chk("starts", n_start - s0, exp_starts);
        chk("stops", n_stop - p0, 1);
        chk("protocol", proto_err - e0, 0);
        if (rd && !exp_nack) chk("master_nack", 32'(last_ack), 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_scl", 32'(scl_oe), 0);
        chk("rst_sda", 32'(sda_oe), 0);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_nack", 32'(rsp_nack), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);

        run_txn(0, SLV, 8'h41, 8'h10, 8'h00, 0);
        run_txn(1, SLV, 8'h42, 8'h00, 8'hA5, 0);
        slave_present = 0;
        run_txn(0, SLV, 8'h41, 8'h10, 8'h00, 0);
        slave_present = 1;
        run_txn(0, SLV, 8'h17, 8'h5C, 8'h00, 1);
        run_txn(1, SLV, 8'h88, 8'h00, 8'h3C, 1);

        // Asynchronous reset during the second data bit of the address byte
        @(negedge clk);
        req_valid = 1'b1; req_read = 1'b0; req_dev_addr = SLV; req_reg_addr = 8'h20; req_wdata = 8'h99;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (8 * D) @(posedge clk);
        #3;
        chk("pre_rst_scl", 32'(scl_oe), 1);
        rst = 1'b1;
        #1;
        chk("arst_scl", 32'(scl_oe), 0);
        chk("arst_sda", 32'(sda_oe), 0);
        chk("arst_ready", 32'(req_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        run_txn(0, SLV, 8'h41, 8'h10, 8'h00, 0);

        for (int n = 0; n < 50; n++) begin
            bit         rd;
            logic [6:0] dev;
            rd  = 1'($urandom_range(0, 1));
            dev = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
            run_txn(rd, dev, 8'($urandom), 8'($urandom), 8'($urandom), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
